// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide unit: multi-cycle multiply, 32-step restoring divide,
// pipeline stall, MTHI/MTLO writes and exception-flush abort.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  mul_con_i,
  input  logic [1:0]  div_con_i,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [1:0]  hilo_we,
  input  logic [31:0] hilo_wdata,
  input  logic        cancel,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic [4:0]  cnt_nxt;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] rem;
  logic        sgn;
  logic        neg_q;
  logic        neg_r;

  logic        ld_div;
  logic        ld_mul;
  logic        div_run;
  logic        mul_we;
  logic        div_we;
  logic        mt_ok;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;

  logic [32:0] r_sh;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] rem_step;
  logic [31:0] q_step;
  logic [31:0] quo;
  logic [31:0] rmd;

  // Divide operands are held as magnitudes; signs are restored at write time.
  assign a_neg = div_con_i[0] & src_a[31];
  assign b_neg = div_con_i[0] & src_b[31];
  assign a_mag = a_neg ? (~src_a + 32'd1) : src_a;
  assign b_mag = b_neg ? (~src_b + 32'd1) : src_b;

  assign ext_a = {{32{sgn & op_a[31]}}, op_a};
  assign ext_b = {{32{sgn & op_b[31]}}, op_b};
  assign prod  = ext_a * ext_b;

  // op_a doubles as the dividend/quotient shift register during DIV.
  assign r_sh     = {rem, op_a[31]};
  assign diff     = r_sh - {1'b0, op_b};
  assign ge       = ~diff[32];
  assign rem_step = ge ? diff[31:0] : r_sh[31:0];
  assign q_step   = {op_a[30:0], ge};
  assign quo      = neg_q ? (~q_step + 32'd1) : q_step;
  assign rmd      = neg_r ? (~rem_step + 32'd1) : rem_step;

  assign done_o = (state == DONE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_o   = 1'b0;
    ld_div    = 1'b0;
    ld_mul    = 1'b0;
    div_run   = 1'b0;
    mul_we    = 1'b0;
    div_we    = 1'b0;
    mt_ok     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!cancel) begin
          if (div_con_i[1]) begin
            state_nxt = DIV;
            cnt_nxt   = 5'd0;
            stall_o   = 1'b1;
            ld_div    = 1'b1;
          end else if (mul_con_i[1]) begin
            state_nxt = MUL;
            cnt_nxt   = 5'd0;
            stall_o   = 1'b1;
            ld_mul    = 1'b1;
          end else begin
            mt_ok = 1'b1;
          end
        end
      end
      MUL: begin
        if (cancel) begin
          state_nxt = IDLE;
          cnt_nxt   = 5'd0;
        end else begin
          stall_o = 1'b1;
          cnt_nxt = cnt + 5'd1;
          if (cnt == MUL_LAST) begin
            state_nxt = DONE;
            cnt_nxt   = 5'd0;
            mul_we    = 1'b1;
          end
        end
      end
      DIV: begin
        if (cancel) begin
          state_nxt = IDLE;
          cnt_nxt   = 5'd0;
        end else begin
          stall_o = 1'b1;
          div_run = 1'b1;
          cnt_nxt = cnt + 5'd1;
          if (cnt == DIV_LAST) begin
            state_nxt = DONE;
            cnt_nxt   = 5'd0;
            div_we    = (op_b != 32'd0);
          end
        end
      end
      DONE: begin
        // The stalled instruction is still on the inputs; never restart here.
        state_nxt = IDLE;
        mt_ok     = ~cancel;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_a  <= 32'd0;
      op_b  <= 32'd0;
      rem   <= 32'd0;
      sgn   <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      unique case (1'b1)
        ld_div: begin
          op_a  <= a_mag;
          op_b  <= b_mag;
          rem   <= 32'd0;
          sgn   <= div_con_i[0];
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
        end
        ld_mul: begin
          op_a <= src_a;
          op_b <= src_b;
          sgn  <= mul_con_i[0];
        end
        div_run: begin
          op_a <= q_step;
          rem  <= rem_step;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_o <= 32'd0;
      lo_o <= 32'd0;
    end else begin
      unique case (1'b1)
        mul_we: begin
          hi_o <= prod[63:32];
          lo_o <= prod[31:0];
        end
        div_we: begin
          hi_o <= rmd;
          lo_o <= quo;
        end
        mt_ok: begin
          if (hilo_we[1]) hi_o <= hilo_wdata;
          if (hilo_we[0]) lo_o <= hilo_wdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed cases plus randomized
// mul/div/cancel/MTHI/MTLO traffic against an arithmetic reference model.
module tb_muldiv_ctrl;

  localparam int MC = 2;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  mul_con_i = '0;
  logic [1:0]  div_con_i = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [1:0]  hilo_we = '0;
  logic [31:0] hilo_wdata = '0;
  logic        cancel = 1'b0;
  logic        stall_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  exp_t exp_q[$];
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  muldiv_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk(clk),
    .resetn(resetn),
    .mul_con_i(mul_con_i),
    .div_con_i(div_con_i),
    .src_a(src_a),
    .src_b(src_b),
    .hilo_we(hilo_we),
    .hilo_wdata(hilo_wdata),
    .cancel(cancel),
    .stall_o(stall_o),
    .done_o(done_o),
    .hi_o(hi_o),
    .lo_o(lo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
  function automatic logic [63:0] model(input bit d, input bit s,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint x;
    longint y;
    longint p;
    longint q;
    longint r;
    x = s ? longint'($signed(a)) : longint'({32'd0, a});
    y = s ? longint'($signed(b)) : longint'({32'd0, b});
    if (!d) begin
      p = x * y;
      return p;
    end
    if (b == 32'd0) return {mhi, mlo};
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (resetn && done_o) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_hi", hi_o, e.hi);
        chk("res_lo", lo_o, e.lo);
        chk("res_cycle", cyc, e.t);
      end
    end
  end

  task automatic set_con(input bit d, input bit s);
    if (d) div_con_i = {1'b1, s};
    else   mul_con_i = {1'b1, s};
  endtask

  task automatic clr_con();
    div_con_i = '0;
    mul_con_i = '0;
  endtask

  task automatic do_op(input bit d, input bit s, input logic [31:0] a,
                       input logic [31:0] b, input bit hold, input bit noise);
    exp_t e;
    logic [63:0] r;
    int lat;
    int t0;
    int nst;
    int n;
    bit seen;
    lat = d ? 33 : MC + 1;
    r = model(d, s, a, b);
    @(posedge clk); #1;
    set_con(d, s);
    src_a = a;
    src_b = b;
    t0 = cyc;
    if (noise) begin
      hilo_we = 2'($urandom_range(0, 3));
      hilo_wdata = $urandom;
    end
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.t = t0 + lat;
    exp_q.push_back(e);
    mhi = e.hi;
    mlo = e.lo;
    #1;
    chk("accept_stall", {31'd0, stall_o}, 32'd1);
    nst = 0;
    seen = 1'b0;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (stall_o) nst++;
      @(posedge clk); #1;
      if (!hold) clr_con();
      if (noise && cyc < t0 + lat) begin
        hilo_we = 2'($urandom_range(0, 3));
        hilo_wdata = $urandom;
      end else begin
        hilo_we = '0;
      end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("stall_cycles", nst, lat);
    chk("done_stall", {31'd0, stall_o}, 32'd0);
    if (hold) begin
      @(posedge clk); #1;
      clr_con();
      @(negedge clk);
      chk("no_restart", {31'd0, stall_o}, 32'd0);
    end
  endtask

  task automatic do_cancel(input bit d, input bit s, input logic [31:0] a,
                           input logic [31:0] b, input int k);
    @(posedge clk); #1;
    set_con(d, s);
    src_a = a;
    src_b = b;
    if (k < 0) cancel = 1'b1;
    #1;
    if (k < 0) chk("cancel_start_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    clr_con();
    if (k >= 0) begin
      repeat (k) @(posedge clk);
      #1;
      cancel = 1'b1;
      #1;
      chk("cancel_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
    end
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_idle", {31'd0, stall_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("cancel_hi", hi_o, mhi);
    chk("cancel_lo", lo_o, mlo);
  endtask

  task automatic mt(input logic [1:0] we, input logic [31:0] v);
    @(posedge clk); #1;
    hilo_we = we;
    hilo_wdata = v;
    @(posedge clk); #1;
    hilo_we = '0;
    if (we[1]) mhi = v;
    if (we[0]) mlo = v;
    @(negedge clk);
    chk("mt_hi", hi_o, mhi);
    chk("mt_lo", lo_o, mlo);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    resetn = 1'b1;

    do_op(1'b0, 1'b1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    chk("tp_muls_hi", hi_o, 32'hFFFFFFFF);
    chk("tp_muls_lo", lo_o, 32'hFFFFFFFA);
    do_op(1'b0, 1'b0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    chk("tp_mulu_hi", hi_o, 32'h00000002);
    chk("tp_mulu_lo", lo_o, 32'hFFFFFFFA);
    do_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    chk("tp_divs_hi", hi_o, 32'hFFFFFFFF);
    chk("tp_divs_lo", lo_o, 32'hFFFFFFFD);
    do_op(1'b1, 1'b0, 32'd7, 32'd2, 1'b1, 1'b0);
    chk("tp_divu_hi", hi_o, 32'd1);
    chk("tp_divu_lo", lo_o, 32'd3);
    do_op(1'b0, 1'b1, 32'd5, 32'hFFFFFFFD, 1'b1, 1'b0);
    do_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    chk("tp_ovf_hi", hi_o, 32'd0);
    chk("tp_ovf_lo", lo_o, 32'h80000000);

    mt(2'b10, 32'h11);
    mt(2'b01, 32'h22);
    do_op(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
    chk("tp_dz_hi", hi_o, 32'h11);
    chk("tp_dz_lo", lo_o, 32'h22);

    do_cancel(1'b1, 1'b1, 32'd100, 32'd7, 10);
    do_op(1'b0, 1'b0, 32'd6, 32'd7, 1'b0, 1'b0);
    chk("tp_42_hi", hi_o, 32'd0);
    chk("tp_42_lo", lo_o, 32'd42);
    do_cancel(1'b1, 1'b0, 32'd9, 32'd2, 31);
    do_cancel(1'b0, 1'b1, 32'd9, 32'd2, MC - 1);
    do_cancel(1'b0, 1'b0, 32'd9, 32'd2, -1);
    do_cancel(1'b1, 1'b0, 32'd9, 32'd2, -1);

    mt(2'b11, 32'hA5A5_0F0F);
    @(posedge clk); #1;
    mul_con_i = 2'b11;
    src_a = 32'd3;
    src_b = 32'd4;
    @(posedge clk); #1;
    clr_con();
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_stall", {31'd0, stall_o}, 32'd0);
    chk("arst_hi", hi_o, 32'd0);
    chk("arst_lo", lo_o, 32'd0);
    mhi = '0;
    mlo = '0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_hold_hi", hi_o, 32'd0);
    do_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      bit d;
      bit s;
      int sel;
      a = $urandom;
      b = $urandom;
      d = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      if (sel == 1) b = 32'($urandom_range(1, 9));
      if (sel == 2) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      if (sel == 3) a = 32'($urandom_range(0, 100));
      if (sel == 4) begin
        mt(2'($urandom_range(1, 3)), $urandom);
      end else if (sel == 5) begin
        do_cancel(d, s, a, b, $urandom_range(0, d ? 31 : MC - 1));
      end else begin
        do_op(d, s, a, b, 1'($urandom_range(0, 1)), 1'b1);
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencing controller and datapath for the HI/LO multiply/divide resource driven by the execute stage's mul_con/div_con controls. It accepts one MUL/MULU/DIV/DIVU per request, runs a multi-cycle multiply or a 32-step restoring divide, and stalls the pipeline until the result is written. It owns the architectural HI/LO registers, including MTHI/MTLO writes, and aborts cleanly on an exception flush from a later stage.

Parameters:
MUL_CYCLES, 2, cycles spent in MUL state before the result is written (legal range 1..8)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
mul_con_i  in  2  {start, signed}; bit1=1 requests a multiply
div_con_i  in  2  {start, signed}; bit1=1 requests a divide
src_a  in  32  rs operand: multiplicand or dividend
src_b  in  32  rt operand: multiplier or divisor
hilo_we  in  2  {hi_we, lo_we}, used for MTHI/MTLO
hilo_wdata  in  32  MTHI/MTLO data
cancel  in  1  exception flush; aborts any operation
stall_o  out  1  hold the IF/ID/EX stages
done_o  out  1  one-cycle pulse in DONE state
hi_o  out  32  HI register
lo_o  out  32  LO register

Behaviour:
- Clock and reset: single clock clk; resetn is asynchronous and active-low. Reset forces state=IDLE, cnt=0, hi_o=0, lo_o=0, done_o=0, stall_o=0.
- States are IDLE, MUL, DIV and DONE.
- IDLE, no cancel:
  - div_con_i[1]=1 -> latch operands and signed flag, go to DIV, cnt=0.
  - else mul_con_i[1]=1 -> latch operands and signed flag, go to MUL, cnt=0.
  - Both starting together is illegal; div has priority.
  - stall_o=1 combinationally in the accepting cycle.
- MUL:
  - Product = 64-bit signed or unsigned product of the latched operands.
  - cnt increments each cycle.
  - When cnt==MUL_CYCLES-1, {HI,LO}<=product and go to DONE.
  - stall_o=1.
- DIV:
  - Restoring division on magnitudes; signed operands are converted via two's complement at latch time.
  - One quotient bit per cycle, 32 cycles (cnt 0..31).
  - On cnt==31, go to DONE and write LO=quotient, HI=remainder with sign fixup: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Divisor==0: HI/LO not written; DONE still reached after 32 cycles.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (natural wrap).
  - stall_o=1.
- DONE:
  - stall_o=0 and done_o=1; lasts exactly one cycle, then IDLE.
  - Start requests are ignored in DONE, because the stalled instruction is still presented while it advances.
- Latency, measured from the accept cycle T0: mul results are visible on hi_o/lo_o at T0+MUL_CYCLES+1 (the DONE cycle); div results at T0+33.
- cancel:
  - In any state, next state is IDLE and no HI/LO write occurs.
  - stall_o=0 in the cancel cycle.
  - A start in the same cycle as cancel is not accepted.
  - Cancel in the final MUL/DIV cycle also suppresses the write.
- hilo_we:
  - Honoured only in IDLE or DONE with no accepted start and no cancel.
  - Writes hilo_wdata to HI and/or LO at the clock edge.
  - Ignored in MUL/DIV.
- hi_o/lo_o are register outputs; they change only at a result write, an MTHI/MTLO write, or reset.
- Reset asserted mid-operation immediately returns to the reset values; no partial write is committed.

Test Plan:
- Signed mul, MUL_CYCLES=2: mul_con=2'b11, a=0xFFFFFFFE, b=3 -> stall_o high for 3 cycles, then done_o; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned mul: mul_con=2'b10, same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- Signed and unsigned div:
  - div_con=2'b11, a=0xFFFFFFF9 (-7), b=2 -> after 33 stalled cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div_con=2'b10, a=7, b=2 -> LO=3, HI=1.
  - Held start during DONE does not restart the operation.
- Divide by zero: HI=0x11, LO=0x22 preset via hilo_we; div a=5, b=0 -> done_o after 33 cycles, HI=0x11, LO=0x22 unchanged.
- Cancel mid-div: cancel pulsed at cycle 10 of DIV -> stall_o=0 that cycle, state IDLE, HI/LO unchanged; a following mul 6*7 gives LO=42, HI=0.
- Async reset mid-mul: deassert resetn between clock edges -> stall_o, hi_o, lo_o drop to 0 immediately, with no clock edge required.
